mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences the single byte-wide RAM port of the core and shares it between two requesters: instruction fetch (IF) and the MEM stage (loads/stores issued by the execution unit with funct3 width).
- Serialises 32-bit fetches and 1/2/4-byte loads/stores into little-endian byte transactions, assembles and sign/zero-extends read data, and returns a one-cycle done pulse to the winning requester.
- Sits between the IF/MEM stages and the top-level RAM interface.

Parameters:
- AddrLen, 32, address width.
- RegLen, 32, data word width.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- if_req_i  input  1  IF fetch request; held until if_done_o.
- if_addr_i  input  AddrLen  fetch address, word-aligned.
- if_done_o  output  1  one-cycle pulse: if_inst_o is valid.
- if_inst_o  output  RegLen  fetched instruction.
- jump_i  input  1  pipeline redirect; cancels any IF fetch.
- mem_load_i  input  1  load request; held until mem_done_o.
- mem_store_i  input  1  store request; held until mem_done_o.
- mem_addr_i  input  AddrLen  load/store byte address.
- mem_funct3_i  input  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_wdata_i  input  RegLen  store data (low bytes used).
- mem_done_o  output  1  one-cycle pulse: access complete, mem_rdata_o valid for loads.
- mem_rdata_o  output  RegLen  extended load data.
- ram_din_i  input  8  byte read from RAM; valid in the cycle after its address.
- ram_dout_o  output  8  byte to write.
- ram_addr_o  output  AddrLen  RAM byte address.
- ram_wr_o  output  1  1 = write, 0 = read.

Behaviour:
- Reset (asynchronous): state IDLE, byte counter 0. All outputs are 0: ram_addr_o, ram_dout_o, ram_wr_o, if_done_o, mem_done_o, if_inst_o, mem_rdata_o.
- FSM states: IDLE, READ, WRITE, DONE.
- Arbitration in IDLE, sampled at the rising edge:
  - MEM (load or store) has fixed priority over IF.
  - IF is accepted only when if_req_i=1 and jump_i=0.
  - mem_load_i and mem_store_i both high is illegal; load wins.
  - On accept, the controller latches owner, base address, byte count n (B/BU=1, H/HU=2, W or fetch=4), funct3 and write data.
- READ timing (accept edge E0):
  - Cycles C1..Cn drive ram_addr_o = base+k with ram_wr_o=0, k=0..n-1.
  - Byte k arrives on ram_din_i in cycle C(k+2) and is written to bits [8k+7:8k].
  - After byte n-1 is captured at the end of C(n+1), the FSM enters DONE and the done pulse is high in C(n+2).
  - A fetch or LW completes with done in C6.
- WRITE timing:
  - Cycles C1..Cn drive ram_addr_o = base+k, ram_wr_o=1 and ram_dout_o = wdata[8k+7:8k].
  - Done pulse in C(n+1). ram_wr_o returns to 0 in the done cycle.
- Address arithmetic: base+k is 32-bit and wraps modulo 2^32. No alignment check.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW is unmodified. Fetches are unmodified.
- DONE state: lasts exactly one cycle, then returns to IDLE.
  - No request is accepted while in DONE, so a requester that drops its request at the edge after done is never re-served.
  - if_inst_o and mem_rdata_o hold their last value until the next completion of the same owner.
- Idle outputs: ram_wr_o=0; ram_addr_o holds its last value.
- jump_i:
  - If high while the owner is IF (READ or DONE), the fetch is aborted. The FSM goes to IDLE at the next edge and no if_done_o is produced.
  - if_done_o is gated combinationally with ~jump_i.
  - A MEM transaction in progress is never affected by jump_i.
- A request arriving during a busy transaction waits; requests are never dropped except IF under jump_i.
- Reset asserted mid-transaction aborts immediately: no done pulse, and ram_wr_o drops asynchronously.

Test Plan:
- Fetch: if_req_i=1, addr 0x100, RAM bytes 0x13,0x05,0x10,0x00 -> ram_addr_o 0x100..0x103 in C1..C4; if_done_o=1 only in C6; if_inst_o=0x00100513.
- LB sign: load funct3=000, addr 0x20 holding 0x80 -> mem_done_o in C3, mem_rdata_o=0xFFFFFF80. Same with LBU -> 0x00000080. LH of bytes 0x34,0xF2 -> 0xFFFFF234.
- SH: store funct3=001, addr 0x40, wdata 0xDEADBEEF -> C1: addr 0x40, dout 0xEF, wr=1; C2: addr 0x41, dout 0xBE, wr=1; C3: mem_done_o=1, wr=0. Bytes 0x42/0x43 are untouched.
- Arbitration: if_req_i and mem_load_i raised in the same cycle -> load served first, then the fetch starts after DONE; mem_done_o precedes if_done_o and no pulse overlaps.
- Redirect: jump_i=1 in C3 of a fetch -> no if_done_o; the next fetch (addr 0x200) restarts cleanly. jump_i during an SW has no effect and mem_done_o appears in C5.
- Reset mid-SW in C2 -> ram_wr_o=0 immediately, all outputs 0, FSM in IDLE; next LW completes normally. Also wrap case: LW at 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial sequencer for the single RAM port, shared by instruction fetch and the MEM stage.
// Splits accesses into little-endian byte cycles, then assembles and extends the read data.
module mem_arbiter #(
    parameter int AddrLen = 32,
    parameter int RegLen  = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               if_req_i,
    input  logic [AddrLen-1:0] if_addr_i,
    output logic               if_done_o,
    output logic [RegLen-1:0]  if_inst_o,
    input  logic               jump_i,
    input  logic               mem_load_i,
    input  logic               mem_store_i,
    input  logic [AddrLen-1:0] mem_addr_i,
    input  logic [2:0]         mem_funct3_i,
    input  logic [RegLen-1:0]  mem_wdata_i,
    output logic               mem_done_o,
    output logic [RegLen-1:0]  mem_rdata_o,
    input  logic [7:0]         ram_din_i,
    output logic [7:0]         ram_dout_o,
    output logic [AddrLen-1:0] ram_addr_o,
    output logic               ram_wr_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    logic [1:0]         state_q, state_d;
    logic               owner_q, owner_d;
    logic [AddrLen-1:0] base_q, base_d;
    logic [2:0]         n_q, n_d;
    logic [2:0]         cyc_q, cyc_d;
    logic [2:0]         f3_q, f3_d;
    logic [RegLen-1:0]  wdata_q, wdata_d;
    logic [RegLen-1:0]  buf_q, buf_d;
    logic [AddrLen-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]         ram_dout_q, ram_dout_d;
    logic               ram_wr_q, ram_wr_d;
    logic               if_done_q, if_done_d;
    logic               mem_done_q, mem_done_d;
    logic [RegLen-1:0]  if_inst_q, if_inst_d;
    logic [RegLen-1:0]  mem_rdata_q, mem_rdata_d;

    logic [AddrLen-1:0] next_addr_s;
    logic [RegLen-1:0]  asm_s;
    logic [1:0]         cap_idx_s;
    logic               more_s;
    logic               capture_s;
    logic               last_s;

    function automatic logic [2:0] byte_count(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   byte_count = 3'd1;
            2'b01:   byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

    function automatic logic [RegLen-1:0] extend(input logic [RegLen-1:0] raw, input logic [2:0] f3);
        case (f3)
            3'b000:  extend = {{(RegLen-8){raw[7]}}, raw[7:0]};
            3'b001:  extend = {{(RegLen-16){raw[15]}}, raw[15:0]};
            3'b100:  extend = {{(RegLen-8){1'b0}}, raw[7:0]};
            3'b101:  extend = {{(RegLen-16){1'b0}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    // Per-cycle address and byte-lane bookkeeping; cyc_q is the index of the current cycle C1..C(n+1).
    always_comb begin
        next_addr_s = base_q + {{(AddrLen-3){1'b0}}, cyc_q};
        more_s      = (cyc_q < n_q);
        capture_s   = (cyc_q >= 3'd2);
        last_s      = (cyc_q == (n_q + 3'd1));
        cap_idx_s   = 2'(cyc_q - 3'd2);
        asm_s       = buf_q;
        if (capture_s) begin
            asm_s[{cap_idx_s, 3'b000} +: 8] = ram_din_i;
        end else begin
            asm_s = buf_q;
        end
    end

    // Arbitration and transaction sequencing.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        base_d      = base_q;
        n_d         = n_q;
        cyc_d       = cyc_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_load_i || mem_store_i) begin
                    owner_d    = OWN_MEM;
                    base_d     = mem_addr_i;
                    n_d        = byte_count(mem_funct3_i);
                    f3_d       = mem_funct3_i;
                    wdata_d    = mem_wdata_i;
                    buf_d      = '0;
                    cyc_d      = 3'd1;
                    ram_addr_d = mem_addr_i;
                    // Both strobes high is illegal; the load takes it.
                    if (mem_load_i) begin
                        state_d = S_READ;
                    end else begin
                        state_d    = S_WRITE;
                        ram_wr_d   = 1'b1;
                        ram_dout_d = mem_wdata_i[7:0];
                    end
                end else if (if_req_i && !jump_i) begin
                    owner_d    = OWN_IF;
                    base_d     = if_addr_i;
                    n_d        = 3'd4;
                    f3_d       = 3'b010;
                    buf_d      = '0;
                    cyc_d      = 3'd1;
                    ram_addr_d = if_addr_i;
                    state_d    = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if ((owner_q == OWN_IF) && jump_i) begin
                    state_d = S_IDLE;
                    cyc_d   = 3'd0;
                end else begin
                    buf_d = asm_s;
                    if (more_s) begin
                        ram_addr_d = next_addr_s;
                    end else begin
                        ram_addr_d = ram_addr_q;
                    end
                    if (last_s) begin
                        state_d = S_DONE;
                        cyc_d   = 3'd0;
                        if (owner_q == OWN_MEM) begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = extend(asm_s, f3_q);
                        end else begin
                            if_done_d = 1'b1;
                            if_inst_d = asm_s;
                        end
                    end else begin
                        cyc_d = cyc_q + 3'd1;
                    end
                end
            end
            S_WRITE: begin
                if (more_s) begin
                    ram_addr_d = next_addr_s;
                    ram_dout_d = wdata_q[{cyc_q[1:0], 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                    cyc_d      = cyc_q + 3'd1;
                end else begin
                    state_d    = S_DONE;
                    cyc_d      = 3'd0;
                    mem_done_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            base_q      <= '0;
            n_q         <= 3'd0;
            cyc_q       <= 3'd0;
            f3_q        <= 3'd0;
            wdata_q     <= '0;
            buf_q       <= '0;
            ram_addr_q  <= '0;
            ram_dout_q  <= 8'd0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            n_q         <= n_d;
            cyc_q       <= cyc_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // A redirect in the done cycle must still suppress the fetch completion.
    assign if_done_o   = if_done_q & ~jump_i;
    assign if_inst_o   = if_inst_q;
    assign mem_done_o  = mem_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_dout_o  = ram_dout_q;
    assign ram_wr_o    = ram_wr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter against a transaction-level model with a byte RAM behind it.
module tb_mem_arbiter;
    localparam int K_IF = 0;
    localparam int K_LD = 1;
    localparam int K_ST = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_done_o;
    logic [31:0] if_inst_o;
    logic        jump_i;
    logic        mem_load_i;
    logic        mem_store_i;
    logic [31:0] mem_addr_i;
    logic [2:0]  mem_funct3_i;
    logic [31:0] mem_wdata_i;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic [7:0]  ram_din_i;
    logic [7:0]  ram_dout_o;
    logic [31:0] ram_addr_o;
    logic        ram_wr_o;

    bit [7:0] ram_mem [1024];
    bit [7:0] ref_mem [1024];
    int n_pass  = 0;
    int n_total = 0;
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    mem_arbiter #(.AddrLen(32), .RegLen(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_inst_o(if_inst_o),
        .jump_i(jump_i),
        .mem_load_i(mem_load_i), .mem_store_i(mem_store_i), .mem_addr_i(mem_addr_i),
        .mem_funct3_i(mem_funct3_i), .mem_wdata_i(mem_wdata_i),
        .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
        .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o)
    );

    always #5 clk_in = ~clk_in;

    // RAM: 1 KiB aliased array, read data one cycle after its address.
    always @(posedge clk_in) begin
        if (ram_wr_o) ram_mem[ram_addr_o[9:0]] <= ram_dout_o;
        ram_din_i <= ram_mem[ram_addr_o[9:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] load_value(input logic [31:0] a, input int n,
                                               input logic [2:0] f3, input bit fetch);
        longint v;
        logic [31:0] ak;
        v = 0;
        for (int k = n - 1; k >= 0; k--) begin
            ak = a + 32'(k);
            v = v * 256 + longint'(ref_mem[ak[9:0]]);
        end
        if (!fetch && f3 == 3'b000 && v >= 128) v = v - 256;
        if (!fetch && f3 == 3'b001 && v >= 32768) v = v - 65536;
        return v[31:0];
    endfunction

    task automatic drop_all();
        if_req_i = 1'b0; mem_load_i = 1'b0; mem_store_i = 1'b0; jump_i = 1'b0;
    endtask

    // One complete transaction, checked every cycle from C1 to the done cycle.
    task automatic run_txn(input int kind, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wd, input logic jmp, output logic [31:0] got);
        int n;
        int dcyc;
        bit is_st;
        logic [31:0] ak;
        logic [31:0] expv;
        is_st = (kind == K_ST);
        if (kind == K_IF) n = 4;
        else if (f3[1:0] == 2'b00) n = 1;
        else if (f3[1:0] == 2'b01) n = 2;
        else n = 4;
        dcyc = is_st ? n + 1 : n + 2;
        expv = 32'd0;
        if (is_st) begin
            for (int k = 0; k < n; k++) begin
                ak = addr + 32'(k);
                ref_mem[ak[9:0]] = wd[8*k +: 8];
            end
        end else begin
            expv = load_value(addr, n, f3, kind == K_IF);
        end
        @(negedge clk_in);
        if_req_i     = (kind == K_IF);
        if_addr_i    = addr;
        mem_load_i   = (kind == K_LD);
        mem_store_i  = is_st;
        mem_addr_i   = addr;
        mem_funct3_i = f3;
        mem_wdata_i  = wd;
        jump_i       = jmp;
        got = 32'd0;
        for (int j = 1; j <= dcyc; j++) begin
            @(negedge clk_in);
            if (j <= n) begin
                chk("ram_addr", ram_addr_o, addr + 32'(j - 1));
                chk("ram_wr", 32'(ram_wr_o), 32'(is_st));
                if (is_st) chk("ram_dout", 32'(ram_dout_o), 32'(wd[8*(j-1) +: 8]));
            end else begin
                chk("ram_wr_tail", 32'(ram_wr_o), 32'd0);
            end
            if (j < dcyc) begin
                chk("if_done_early", 32'(if_done_o), 32'd0);
                chk("mem_done_early", 32'(mem_done_o), 32'd0);
            end else begin
                chk("if_done", 32'(if_done_o), 32'(kind == K_IF));
                chk("mem_done", 32'(mem_done_o), 32'(kind != K_IF));
                got = (kind == K_IF) ? if_inst_o : mem_rdata_o;
                if (!is_st) chk("rdata", got, expv);
            end
        end
        drop_all();
    endtask

    initial begin
        logic [31:0] got;
        int md;
        int fd;
        int ov;
        int seen;
        int kind;
        logic [31:0] a;
        logic [2:0] f;

        rst_in = 1'b1; drop_all();
        if_addr_i = 32'd0; mem_addr_i = 32'd0; mem_funct3_i = 3'd0; mem_wdata_i = 32'd0;
        repeat (2) @(negedge clk_in);
        chk("rst_addr", ram_addr_o, 32'd0);
        chk("rst_dout", 32'(ram_dout_o), 32'd0);
        chk("rst_wr", 32'(ram_wr_o), 32'd0);
        chk("rst_if_done", 32'(if_done_o), 32'd0);
        chk("rst_mem_done", 32'(mem_done_o), 32'd0);
        chk("rst_inst", if_inst_o, 32'd0);
        chk("rst_rdata", mem_rdata_o, 32'd0);
        rst_in = 1'b0;

        // Directed cases with hand-computed results.
        run_txn(K_ST, 32'h100, 3'b010, 32'h00100513, 1'b0, got);
        run_txn(K_IF, 32'h100, 3'b010, 32'd0, 1'b0, got);
        chk("fetch_lit", got, 32'h00100513);
        run_txn(K_ST, 32'h20, 3'b000, 32'h00000080, 1'b0, got);
        run_txn(K_LD, 32'h20, 3'b000, 32'd0, 1'b0, got);
        chk("lb_lit", got, 32'hFFFFFF80);
        run_txn(K_LD, 32'h20, 3'b100, 32'd0, 1'b0, got);
        chk("lbu_lit", got, 32'h00000080);
        run_txn(K_ST, 32'h30, 3'b001, 32'h0000F234, 1'b0, got);
        run_txn(K_LD, 32'h30, 3'b001, 32'd0, 1'b0, got);
        chk("lh_lit", got, 32'hFFFFF234);
        run_txn(K_ST, 32'h40, 3'b010, 32'h00000000, 1'b0, got);
        run_txn(K_ST, 32'h40, 3'b001, 32'hDEADBEEF, 1'b0, got);
        run_txn(K_LD, 32'h40, 3'b010, 32'd0, 1'b0, got);
        chk("sh_untouched_lit", got, 32'h0000BEEF);

        // Simultaneous fetch and load: load first, fetch after DONE, pulses disjoint.
        @(negedge clk_in);
        if_req_i = 1'b1; if_addr_i = 32'h100;
        mem_load_i = 1'b1; mem_addr_i = 32'h100; mem_funct3_i = 3'b010;
        md = 0; fd = 0; ov = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk_in);
            if (mem_done_o && if_done_o) ov++;
            if (mem_done_o) begin
                md = c; chk("arb_rdata", mem_rdata_o, 32'h00100513); mem_load_i = 1'b0;
            end
            if (if_done_o) begin
                fd = c; chk("arb_inst", if_inst_o, 32'h00100513); if_req_i = 1'b0;
            end
        end
        chk("arb_mem_cycle", 32'(md), 32'd6);
        chk("arb_if_cycle", 32'(fd), 32'd13);
        chk("arb_overlap", 32'(ov), 32'd0);
        drop_all();

        // Redirect in C3 of a fetch, then a clean fetch from 0x200.
        run_txn(K_ST, 32'h200, 3'b010, 32'h12345678, 1'b0, got);
        @(negedge clk_in);
        if_req_i = 1'b1; if_addr_i = 32'h100;
        seen = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_in);
            if (if_done_o) seen++;
            if (c == 3) jump_i = 1'b1;
            if (c == 4) begin
                chk("jmp_wr", 32'(ram_wr_o), 32'd0);
                chk("jmp_addr_hold", ram_addr_o, 32'h102);
                jump_i = 1'b0; if_req_i = 1'b0;
            end
        end
        chk("jmp_no_done", 32'(seen), 32'd0);
        run_txn(K_IF, 32'h200, 3'b010, 32'd0, 1'b0, got);
        chk("refetch_lit", got, 32'h12345678);
        run_txn(K_ST, 32'h50, 3'b010, 32'hA5A5A5A5, 1'b1, got);

        // Reset in C2 of a word store: only byte 0 reached RAM.
        @(negedge clk_in);
        mem_store_i = 1'b1; mem_addr_i = 32'h300; mem_funct3_i = 3'b010; mem_wdata_i = 32'h11223344;
        @(negedge clk_in);
        chk("rsw_c1_wr", 32'(ram_wr_o), 32'd1);
        @(posedge clk_in);
        #1 rst_in = 1'b1;
        #1;
        chk("rsw_wr", 32'(ram_wr_o), 32'd0);
        chk("rsw_addr", ram_addr_o, 32'd0);
        chk("rsw_dout", 32'(ram_dout_o), 32'd0);
        chk("rsw_mem_done", 32'(mem_done_o), 32'd0);
        chk("rsw_rdata", mem_rdata_o, 32'd0);
        chk("rsw_inst", if_inst_o, 32'd0);
        ref_mem[10'h300] = 8'h44;
        drop_all();
        @(negedge clk_in);
        rst_in = 1'b0;
        run_txn(K_LD, 32'h300, 3'b010, 32'd0, 1'b0, got);
        chk("rsw_load_lit", got, 32'h00000044);

        // Address wrap past 0xFFFFFFFF.
        run_txn(K_ST, 32'hFFFFFFFE, 3'b010, 32'hCAFEF00D, 1'b0, got);
        run_txn(K_LD, 32'hFFFFFFFE, 3'b010, 32'd0, 1'b0, got);
        chk("wrap_lit", got, 32'hCAFEF00D);

        // Random mix of fetches, loads and stores.
        for (int t = 0; t < 80; t++) begin
            kind = int'($urandom_range(0, 2));
            a = $urandom;
            if (kind == K_IF) begin
                a[1:0] = 2'b00;
                run_txn(K_IF, a, 3'b010, 32'd0, 1'b0, got);
            end else if (kind == K_LD) begin
                f = ld_f3[$urandom_range(0, 4)];
                run_txn(K_LD, a, f, 32'd0, 1'($urandom_range(0, 1)), got);
            end else begin
                f = 3'($urandom_range(0, 2));
                run_txn(K_ST, a, f, $urandom, 1'($urandom_range(0, 1)), got);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
